// File: rtl/pkt_admit_buffer.sv
// rtl/pkt_admit_buffer.sv - store-and-forward packet admission buffer
//
// Buffers each packet from the 64-bit data / 8-bit ctrl stream until its EOP
// word has arrived, then releases it downstream. Packets longer than
// MAX_PKT_WORDS are discarded whole and counted.
//
// Ports:
//   clk, reset                       single clock, synchronous active-high reset
//   in_data, in_ctrl, in_wr, in_rdy  upstream word stream (in_wr only while in_rdy)
//   out_data, out_ctrl, out_wr       head word, valid when out_wr (transfer this cycle)
//   out_rdy                          downstream can accept
//   pkt_in_count                     packets committed to the buffer
//   pkt_out_count                    packets whose EOP word has been sent
//   drop_count                       oversize packets discarded

module pkt_admit_buffer #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int MAX_PKT_WORDS = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pkt_in_count,
  output logic [31:0]           pkt_out_count,
  output logic [31:0]           drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int LEN_W = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {S_SOP, S_BODY, S_DROP} wr_state_t;

  logic [WW-1:0]         r_mem [0:DEPTH-1];

  wr_state_t             r_state;
  wr_state_t             w_next_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_commit_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_fetch_ptr;
  logic [LEN_W-1:0]      r_pkt_len;
  logic                  r_seen_body;
  logic [31:0]           r_pkt_in_count;
  logic [31:0]           r_pkt_out_count;
  logic [31:0]           r_drop_count;

  logic                  r_head_valid;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [CTRL_WIDTH-1:0] r_head_ctrl;
  logic                  r_rd_body;

  logic [PW-1:0]         w_used;
  logic                  w_accept;
  logic                  w_in_is_ctrl;
  logic                  w_oversize;
  logic                  w_mem_we;
  logic                  w_commit;
  logic                  w_drop;
  logic                  w_head_load;

  // Uncommitted words and the word sitting in the head register both count
  // as used, so the RAM can never be overwritten before it is sent.
  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign in_rdy       = (r_state == S_DROP) || (w_used < PW'(DEPTH));
  assign w_accept     = in_wr && in_rdy;
  assign w_in_is_ctrl = (in_ctrl != '0);
  // The incoming word would be number MAX_PKT_WORDS+1 of this packet.
  assign w_oversize   = (r_pkt_len == LEN_W'(MAX_PKT_WORDS));

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SOP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SOP: begin
        if (w_accept) begin
          if (w_oversize)         w_next_state = S_DROP;
          else if (!w_in_is_ctrl) w_next_state = S_BODY;
        end
      end
      S_BODY: begin
        if (w_accept) begin
          // An EOP always ends the packet; if it is also the oversize word the
          // packet is already complete, so there is nothing left to discard.
          if (w_in_is_ctrl)    w_next_state = S_SOP;
          else if (w_oversize) w_next_state = S_DROP;
        end
      end
      S_DROP: begin
        if (w_accept && w_in_is_ctrl && r_seen_body) w_next_state = S_SOP;
      end
      default: w_next_state = S_SOP;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    w_mem_we = 1'b0;
    w_commit = 1'b0;
    w_drop   = 1'b0;
    if (w_accept && (r_state != S_DROP)) begin
      if (w_oversize) begin
        w_drop = 1'b1;
      end else begin
        w_mem_we = 1'b1;
        w_commit = (r_state == S_BODY) && w_in_is_ctrl;
      end
    end
  end

  // ---------------- write-side pointers and counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_commit_ptr   <= '0;
      r_pkt_len      <= '0;
      r_seen_body    <= 1'b0;
      r_pkt_in_count <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_mem_we) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_pkt_len <= r_pkt_len + LEN_W'(1);
      end
      if (w_commit) begin
        r_commit_ptr   <= r_wr_ptr + PW'(1);
        r_pkt_in_count <= r_pkt_in_count + 32'd1;
        r_pkt_len      <= '0;
      end
      if (w_drop) begin
        // Rewind over the partial packet; its slots become free immediately.
        r_wr_ptr     <= r_commit_ptr;
        r_drop_count <= r_drop_count + 32'd1;
        r_pkt_len    <= '0;
        r_seen_body  <= (r_state == S_BODY) || !w_in_is_ctrl;
      end
      if ((r_state == S_DROP) && w_accept && !w_in_is_ctrl) begin
        r_seen_body <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {in_ctrl, in_data};
    end
  end

  // ---------------- read side ----------------
  // r_fetch_ptr is the next RAM word to load; r_rd_ptr is the word in the head
  // register (or the next to load when the head is empty).
  assign out_wr      = r_head_valid && out_rdy;
  assign w_head_load = (r_fetch_ptr != r_commit_ptr) && (!r_head_valid || out_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_ptr     <= '0;
      r_rd_ptr        <= '0;
      r_head_valid    <= 1'b0;
      r_head_data     <= '0;
      r_head_ctrl     <= '0;
      r_rd_body       <= 1'b0;
      r_pkt_out_count <= '0;
    end else begin
      if (w_head_load) begin
        {r_head_ctrl, r_head_data} <= r_mem[r_fetch_ptr[ADDR_WIDTH-1:0]];
        r_fetch_ptr                <= r_fetch_ptr + PW'(1);
        r_head_valid               <= 1'b1;
      end else if (out_wr) begin
        r_head_valid <= 1'b0;
      end
      if (out_wr) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        if (r_head_ctrl == '0) begin
          r_rd_body <= 1'b1;
        end else if (r_rd_body) begin
          r_rd_body       <= 1'b0;
          r_pkt_out_count <= r_pkt_out_count + 32'd1;
        end
      end
    end
  end

  assign out_data      = r_head_data;
  assign out_ctrl      = r_head_ctrl;
  assign pkt_in_count  = r_pkt_in_count;
  assign pkt_out_count = r_pkt_out_count;
  assign drop_count    = r_drop_count;

endmodule
